// File: rtl/weight_load_ctrl_pkg.sv
// Shared types and default geometry for the weight-load controller.
package Config;

    localparam int unsigned W_rows   = 4;
    localparam int unsigned sys_cols = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DRAIN  = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } wlc_state_t;

    // Index width that stays legal (>= 1 bit) for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end
        return 32'd1;
    endfunction

endpackage

// File: rtl/weight_load_ctrl_down_counter.sv
// Loadable down counter with a zero flag; times the skew-drain window.
module wlc_down_counter
    import Config::*;
#(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_zero_c
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Load wins over decrement; decrement never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_zero_c = (count_q == '0);

endmodule

// File: rtl/weight_load_ctrl.sv
// Streams ROWS weight rows per tile, waits out the column skew, then commits the tile.
// Optional stall_cycles performance counter when WEIGHT_LOAD_CTRL_PERF_EN is defined.
module weight_load_ctrl
    import Config::*;
#(
    parameter int unsigned ROWS   = W_rows,
    parameter int unsigned COLS   = sys_cols,
    parameter int unsigned TILE_W = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic [TILE_W-1:0]           n_tiles,
    input  logic                        stall,
    output logic                        read,
    output logic                        w_load,
    output logic                        busy,
    output logic [idx_width(ROWS)-1:0]  row_idx,
    output logic [TILE_W-1:0]           tile_idx,
    output logic                        all_done
`ifdef WEIGHT_LOAD_CTRL_PERF_EN
    ,
    output logic [31:0]                 stall_cycles
`endif
);

    localparam int unsigned RIDX_W = idx_width(ROWS);
    localparam int unsigned DRN_W  = idx_width(COLS);
    localparam int unsigned TW1    = TILE_W + 1;

    wlc_state_t          state_d, state_q;
    logic [RIDX_W-1:0]   row_idx_d, row_idx_q;
    logic [TILE_W-1:0]   tile_idx_d, tile_idx_q;
    logic [TILE_W-1:0]   n_tiles_d, n_tiles_q;
    logic                busy_d, busy_q;
    logic                w_load_d, w_load_q;
    logic                all_done_d, all_done_q;
    logic                drain_load;
    logic                drain_dec;
    logic                drain_zero_c;
    logic                more_tiles_c;

    assign read         = (state_q == FETCH) && !stall;
    assign more_tiles_c = ({1'b0, tile_idx_q} + TW1'(1)) < {1'b0, n_tiles_q};

    // Drain window: loaded with COLS-1 on the last read, so DRAIN spans COLS cycles.
    wlc_down_counter #(
        .W (DRN_W)
    ) u_drain_cnt (
        .clk       (clk),
        .rstn      (rstn),
        .load      (drain_load),
        .load_val  (DRN_W'(COLS - 1)),
        .dec       (drain_dec),
        .is_zero_c (drain_zero_c)
    );

    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        tile_idx_d = tile_idx_q;
        n_tiles_d  = n_tiles_q;
        drain_load = 1'b0;
        drain_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    row_idx_d  = '0;
                    tile_idx_d = '0;
                    n_tiles_d  = n_tiles;
                    state_d    = (n_tiles != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (read) begin
                    if (row_idx_q == RIDX_W'(ROWS - 1)) begin
                        row_idx_d  = '0;
                        drain_load = 1'b1;
                        state_d    = DRAIN;
                    end else begin
                        row_idx_d = row_idx_q + RIDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_zero_c) begin
                    state_d = COMMIT;
                end else begin
                    drain_dec = 1'b1;
                end
            end
            COMMIT: begin
                if (more_tiles_c) begin
                    tile_idx_d = tile_idx_q + TILE_W'(1);
                    state_d    = FETCH;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs decoded from the next state so they register in step with it.
        busy_d     = (state_d != IDLE);
        w_load_d   = (state_d == COMMIT);
        all_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            row_idx_q  <= '0;
            tile_idx_q <= '0;
            n_tiles_q  <= '0;
            busy_q     <= 1'b0;
            w_load_q   <= 1'b0;
            all_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            tile_idx_q <= tile_idx_d;
            n_tiles_q  <= n_tiles_d;
            busy_q     <= busy_d;
            w_load_q   <= w_load_d;
            all_done_q <= all_done_d;
        end
    end

    assign busy     = busy_q;
    assign w_load   = w_load_q;
    assign all_done = all_done_q;
    assign row_idx  = row_idx_q;
    assign tile_idx = tile_idx_q;

`ifdef WEIGHT_LOAD_CTRL_PERF_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;

    // Saturating count of stalled FETCH cycles, restarted by every accepted start.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start) begin
            stall_cnt_d = '0;
        end else if ((state_q == FETCH) && stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed + randomized bench for weight_load_ctrl against a timeline model of a load job.
module tb_weight_load_ctrl;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned TILE_W = 8;
    localparam int          MAXC   = 512;
    localparam int          SCAP   = 300;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic              stall;
    logic [TILE_W-1:0] n_tiles;
    logic              read;
    logic              w_load;
    logic              busy;
    logic [1:0]        row_idx;
    logic [TILE_W-1:0] tile_idx;
    logic              all_done;
`ifdef WEIGHT_LOAD_CTRL_PERF_EN
    logic [31:0]       stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    bit st      [MAXC];
    bit e_read  [MAXC];
    bit e_wload [MAXC];
    bit e_done  [MAXC];
    int e_row   [MAXC];
    int e_tile  [MAXC];
    int e_len;
    int e_stalls;
    int o_reads, o_wloads, o_dones, o_first_wload, o_done_c;

    always #5 clk = ~clk;

    weight_load_ctrl #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .TILE_W (TILE_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .n_tiles      (n_tiles),
        .stall        (stall),
        .read         (read),
        .w_load       (w_load),
        .busy         (busy),
        .row_idx      (row_idx),
        .tile_idx     (tile_idx),
        .all_done     (all_done)
`ifdef WEIGHT_LOAD_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".read"},     0, 32'(read),     32'd0);
        check({tag, ".w_load"},   0, 32'(w_load),   32'd0);
        check({tag, ".all_done"}, 0, 32'(all_done), 32'd0);
        check({tag, ".busy"},     0, 32'(busy),     32'd0);
        check({tag, ".row_idx"},  0, 32'(row_idx),  32'd0);
        check({tag, ".tile_idx"}, 0, 32'(tile_idx), 32'd0);
`ifdef WEIGHT_LOAD_CTRL_PERF_EN
        check({tag, ".stall_cycles"}, 0, stall_cycles, 32'd0);
`endif
    endtask

    // Expected job timeline: per tile, ROWS un-stalled reads, COLS drain cycles,
    // one commit cycle; then one done cycle. Cycle 1 follows the accepting edge.
    task automatic build_model(input int n);
        int c;
        c = 1;
        e_stalls = 0;
        for (int i = 0; i < MAXC; i++) begin
            e_read[i] = 1'b0; e_wload[i] = 1'b0; e_done[i] = 1'b0;
            e_row[i] = 0; e_tile[i] = 0;
        end
        for (int t = 0; t < n; t++) begin
            int r;
            r = 0;
            while (r < int'(ROWS)) begin
                e_row[c]  = r;
                e_tile[c] = t;
                if (st[c]) e_stalls++;
                else begin e_read[c] = 1'b1; r++; end
                c++;
            end
            for (int k = 0; k < int'(COLS) + 1; k++) begin
                e_tile[c] = t;
                c++;
            end
            e_wload[c-1] = 1'b1;
        end
        e_tile[c] = (n == 0) ? 0 : n - 1;
        e_done[c] = 1'b1;
        e_len     = c;
    endtask

    // stall_pct < 0 keeps a pattern pre-loaded into st[]; abort_c > 0 resets mid-job.
    task automatic run_job(input string tag, input int n, input int stall_pct,
                           input bit busy_starts, input int abort_c);
        if (stall_pct >= 0) begin
            for (int i = 0; i < MAXC; i++)
                st[i] = (i < SCAP) && (int'($urandom_range(99)) < stall_pct);
        end
        build_model(n);
        o_reads = 0; o_wloads = 0; o_dones = 0; o_first_wload = 0; o_done_c = 0;
        @(posedge clk); #1;
        start   = 1'b1;
        n_tiles = TILE_W'(n);
        stall   = 1'($urandom_range(1));
        for (int c = 1; c <= e_len + 1; c++) begin
            @(posedge clk); #1;
            start   = busy_starts && (c <= e_len) && ($urandom_range(3) == 0);
            n_tiles = TILE_W'($urandom_range(5));
            stall   = st[c];
            #1;
            check({tag, ".read"},     c, 32'(read),     32'(e_read[c]));
            check({tag, ".w_load"},   c, 32'(w_load),   32'(e_wload[c]));
            check({tag, ".all_done"}, c, 32'(all_done), 32'(e_done[c]));
            check({tag, ".busy"},     c, 32'(busy),     32'(c <= e_len));
            check({tag, ".row_idx"},  c, 32'(row_idx),  32'(e_row[c]));
            if (c <= e_len) check({tag, ".tile_idx"}, c, 32'(tile_idx), 32'(e_tile[c]));
`ifdef WEIGHT_LOAD_CTRL_PERF_EN
            if (c == 1)     check({tag, ".stall_clr"}, c, stall_cycles, 32'd0);
            if (c == e_len) check({tag, ".stall_cnt"}, c, stall_cycles, 32'(e_stalls));
`endif
            if (read) o_reads++;
            if (w_load) begin
                o_wloads++;
                if (o_first_wload == 0) o_first_wload = c;
            end
            if (all_done) begin
                o_dones++;
                o_done_c = c;
            end
            if (c == abort_c) begin
                rstn  = 1'b0;
                start = 1'b0;
                #1;
                check_all_zero({tag, ".in_reset"});
                @(negedge clk);
                rstn = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    check_all_zero({tag, ".after_reset"});
                end
                return;
            end
        end
        start = 1'b0;
        check({tag, ".n_reads"},  0, 32'(o_reads),  32'(n * int'(ROWS)));
        check({tag, ".n_wloads"}, 0, 32'(o_wloads), 32'(n));
        check({tag, ".n_dones"},  0, 32'(o_dones),  32'd1);
        check({tag, ".done_cycle"}, 0, 32'(o_done_c),
              32'(n * int'(ROWS + COLS + 1) + 1 + e_stalls));
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; stall = 1'b0; n_tiles = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < MAXC; i++) st[i] = 1'b0;
        run_job("single", 1, -1, 1'b0, 0);
        check("single.first_wload", 0, 32'(o_first_wload), 32'(ROWS + COLS + 1));
        check("single.total", 0, 32'(o_done_c), 32'd10);

        run_job("three", 3, 0, 1'b1, 0);

        for (int i = 0; i < MAXC; i++) st[i] = 1'b0;
        st[3] = 1'b1; st[4] = 1'b1;
        run_job("stall2", 2, -1, 1'b0, 0);
        check("stall2.first_wload", 0, 32'(o_first_wload), 32'(ROWS + COLS + 1 + 2));

        run_job("zero", 0, 0, 1'b0, 0);
        check("zero.done_cycle", 0, 32'(o_done_c), 32'd1);
        run_job("zero_busy", 0, 0, 1'b1, 0);

        run_job("abort", 2, 0, 1'b1, int'(ROWS + COLS + 1) + 3);
        run_job("fresh", 1, 0, 1'b0, 0);

        for (int i = 0; i < MAXC; i++) st[i] = 1'b0;
        for (int i = 2; i <= 6; i++) st[i] = 1'b1;
        run_job("stall5", 1, -1, 1'b1, 0);
        check("stall5.stalls_in_fetch", 0, 32'(e_stalls), 32'd5);
        run_job("after5", 1, 0, 1'b0, 0);

        for (int j = 0; j < 8; j++) begin
            run_job("rand", int'($urandom_range(4, 1)), 25, 1'b1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/weight_load_ctrl.md
WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
REQ-001 Parameter ROWS, default W_rows, SHALL set the weight rows streamed per tile (read pulses per tile).
REQ-002 Parameter COLS, default sys_cols, SHALL set the systolic column count, which determines skew drain length.
REQ-003 Parameter TILE_W, default 8, SHALL set the width of the tile-count and tile-index fields.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL be a one-cycle request to begin a load job; sampled only in IDLE.
REQ-007 n_tiles  input  TILE_W  SHALL give the tiles in the job; sampled with accepted start.
REQ-008 stall  input  1  SHALL be downstream backpressure; when high, no read is issued.
REQ-009 read  output  1  SHALL be the read strobe to weight buffer column 0.
REQ-010 w_load  output  1  SHALL be a one-cycle pulse latching a complete tile into the PEs.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 row_idx  output  $clog2(ROWS)  SHALL give the current row count within a tile.
REQ-013 tile_idx  output  TILE_W  SHALL give the current tile number.
REQ-014 all_done  output  1  SHALL be a one-cycle pulse at job completion.

Function
REQ-015 States SHALL be IDLE, FETCH, DRAIN, COMMIT and DONE.
REQ-016 IDLE SHALL move to FETCH on start with n_tiles != 0, latching n_tiles and clearing row_idx and tile_idx.
REQ-017 IDLE with start and n_tiles == 0 SHALL move to DONE without issuing any read.
REQ-018 In FETCH, read SHALL equal !stall combinationally, and row_idx SHALL increment on each cycle with read high.
REQ-019 FETCH SHALL move to DRAIN in the cycle after the read at row_idx == ROWS-1, and row_idx SHALL wrap to 0.
REQ-020 DRAIN SHALL last exactly COLS cycles (COLS-1 skew plus 1 buffer read latency), hold read low and ignore stall.
REQ-021 COMMIT SHALL last one cycle with w_load high.
REQ-022 COMMIT SHALL go to FETCH with tile_idx+1 when tile_idx+1 < n_tiles latched, otherwise to DONE.
REQ-023 DONE SHALL last one cycle with all_done high, then return to IDLE.
REQ-024 start outside IDLE SHALL be ignored, and no queued start SHALL be kept.
REQ-025 A job of N tiles with no stall SHALL take N*(ROWS+COLS+1)+1 cycles from start acceptance to all_done.
REQ-026 read, w_load and all_done SHALL never be high in the same cycle.

Reset
REQ-027 rstn low SHALL force IDLE immediately, including mid-job; the partial tile is discarded with no w_load.
REQ-028 During and after reset, read, w_load, busy and all_done SHALL be 0, and row_idx, tile_idx and all counters SHALL be 0.

Configuration
REQ-029 With WEIGHT_LOAD_CTRL_PERF_EN defined, the block SHALL add output stall_cycles (32 bits), counting FETCH cycles with stall high, saturating, cleared on accepted start.
REQ-030 Without WEIGHT_LOAD_CTRL_PERF_EN, the port and counter SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-031 The state enum type wlc_state_t, plus sys_cols and W_rows, SHALL live in package Config.
REQ-032 The DRAIN counter SHALL be a sub-module wlc_down_counter (load value, decrement, zero flag); row and tile counters SHALL stay inline.

Verification
REQ-033 ROWS=4, COLS=4, n_tiles=1, no stall: read high 4 cycles, w_load 4 cycles later, all_done next cycle; 10 cycles total.
REQ-034 n_tiles=3: exactly 12 read pulses, 3 w_load pulses and tile_idx sequence 0,1,2, then a single all_done.
REQ-035 stall high 2 cycles after the second read: read low exactly those 2 cycles, row_idx holds, w_load delayed by 2 cycles.
REQ-036 start with n_tiles=0: no read, no w_load, all_done 1 cycle later; start while busy changes no output.
REQ-037 rstn low at the 3rd read of tile 1: next sampled outputs all 0, state IDLE, and a fresh start completes normally.
REQ-038 PERF_EN build with 5 stall cycles in FETCH: stall_cycles=5 at all_done, and 0 after the next accepted start.
